// File: rtl/stack_pkg.sv
// Shared definitions for the stack pointer unit.
// Op encodings and the entry-count width helper.
package stack_pkg;

  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_PUSH = 2'b01;
  localparam logic [1:0] SP_POP  = 2'b10;
  localparam logic [1:0] SP_LOAD = 2'b11;

  // Bits needed to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < (depth + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/stack_bound_check.sv
// Classifies the requested op against the current entry count.
// Decides whether it is legal and which error it raises if not.
module stack_bound_check
  import stack_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic [CW-1:0] count_i,
  input  logic [1:0]    op_i,
  input  logic [CW-1:0] load_depth_i,
  output logic          do_inc_o,
  output logic          do_dec_o,
  output logic          do_load_o,
  output logic          set_ovf_o,
  output logic          set_unf_o
);

  logic is_full;
  logic is_empty;
  logic ld_ok;

  assign is_full  = (count_i == CW'(DEPTH));
  assign is_empty = (count_i == '0);
  assign ld_ok    = (load_depth_i <= CW'(DEPTH));

  // Op decode: legal ops move the pointer, illegal ones only flag.
  always_comb begin
    do_inc_o  = 1'b0;
    do_dec_o  = 1'b0;
    do_load_o = 1'b0;
    set_ovf_o = 1'b0;
    set_unf_o = 1'b0;
    unique case (op_i)
      SP_HOLD: ;
      SP_PUSH: begin
        set_ovf_o = is_full;
        do_inc_o  = !is_full;
      end
      SP_POP: begin
        set_unf_o = is_empty;
        do_dec_o  = !is_empty;
      end
      SP_LOAD: begin
        set_ovf_o = !ld_ok;
        do_load_o = ld_ok;
      end
    endcase
  end

endmodule

// File: rtl/stack_pointer_unit.sv
// Parametrised stack pointer with full/empty status and
// sticky overflow/underflow flags; sp/top feed the stack RAM.
module stack_pointer_unit
  import stack_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int BASE  = 16384,
  parameter  int DEPTH = 256,
  parameter  int STEP  = 1,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [CW-1:0]    load_depth,
  input  logic             err_clr,
  output logic [WIDTH-1:0] sp,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] BASE_W = WIDTH'(BASE);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] TOP0_W = BASE_W - STEP_W;

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic do_inc, do_dec, do_load;
  logic set_ovf, set_unf;

  logic [WIDTH-1:0] sp_ld;
  logic [WIDTH-1:0] top_ld;

  stack_bound_check #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_bound (
    .count_i      (count_q),
    .op_i         (op),
    .load_depth_i (load_depth),
    .do_inc_o     (do_inc),
    .do_dec_o     (do_dec),
    .do_load_o    (do_load),
    .set_ovf_o    (set_ovf),
    .set_unf_o    (set_unf)
  );

  // The only multiplier: absolute load target.
  assign sp_ld  = BASE_W + WIDTH'(load_depth) * STEP_W;
  assign top_ld = sp_ld - STEP_W;

  // Next pointer state; incremental ops use adders only.
  always_comb begin
    count_d = count_q;
    sp_d    = sp_q;
    top_d   = top_q;
    unique case (1'b1)
      do_inc: begin
        count_d = count_q + CW'(1);
        sp_d    = sp_q + STEP_W;
        top_d   = top_q + STEP_W;
      end
      do_dec: begin
        count_d = count_q - CW'(1);
        sp_d    = sp_q - STEP_W;
        top_d   = top_q - STEP_W;
      end
      do_load: begin
        count_d = load_depth;
        sp_d    = sp_ld;
        top_d   = top_ld;
      end
      default: ;
    endcase
  end

  // A new error beats err_clr for its own flag.
  always_comb begin
    ovf_d = set_ovf | (ovf_q & !err_clr);
    unf_d = set_unf | (unf_q & !err_clr);
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      count_q <= '0;
      sp_q    <= BASE_W;
      top_q   <= TOP0_W;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sp_q    <= sp_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign sp        = sp_q;
  assign top       = top_q;
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit.
// Two instances: DEPTH=4/STEP=1 and DEPTH=8/STEP=2.
module tb_stack_pointer_unit;

  logic        CLK;
  logic        reset;
  logic [1:0]  op_a, op_b;
  logic [2:0]  ld_a;
  logic [3:0]  ld_b;
  logic        clr_a, clr_b;

  logic [15:0] sp_a, top_a, sp_b, top_b;
  logic [2:0]  cnt_a;
  logic [3:0]  cnt_b;
  logic        full_a, empty_a, ovf_a, unf_a;
  logic        full_b, empty_b, ovf_b, unf_b;

  int checks = 0;
  int errors = 0;

  stack_pointer_unit #(
    .WIDTH (16), .BASE (16384), .DEPTH (4), .STEP (1)
  ) dut_a (
    .CLK        (CLK),
    .reset      (reset),
    .op         (op_a),
    .load_depth (ld_a),
    .err_clr    (clr_a),
    .sp         (sp_a),
    .top        (top_a),
    .count      (cnt_a),
    .full       (full_a),
    .empty      (empty_a),
    .overflow   (ovf_a),
    .underflow  (unf_a)
  );

  stack_pointer_unit #(
    .WIDTH (16), .BASE (16384), .DEPTH (8), .STEP (2)
  ) dut_b (
    .CLK        (CLK),
    .reset      (reset),
    .op         (op_b),
    .load_depth (ld_b),
    .err_clr    (clr_b),
    .sp         (sp_b),
    .top        (top_b),
    .count      (cnt_b),
    .full       (full_b),
    .empty      (empty_b),
    .overflow   (ovf_b),
    .underflow  (unf_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus; returns at the next falling edge.
  task automatic cyc_a(input logic [1:0] o, input int ld,
                       input logic clr, input logic rst);
    op_a  = o;
    ld_a  = 3'(ld);
    clr_a = clr;
    reset = rst;
    @(negedge CLK);
    op_a  = 2'b00;
    clr_a = 1'b0;
    reset = 1'b0;
  endtask

  task automatic cyc_b(input logic [1:0] o, input int ld);
    op_b = o;
    ld_b = 4'(ld);
    @(negedge CLK);
    op_b = 2'b00;
  endtask

  // Pointer/count relationship and full/empty exclusivity.
  always @(negedge CLK) begin
    if (!reset) begin
      chk("inv_sp_a", 32'(sp_a), 32'd16384 + 32'(cnt_a));
      chk("inv_sp_b", 32'(sp_b), 32'd16384 + 32'(cnt_b) * 2);
      chk("inv_fe_a", 32'(full_a & empty_a), 32'd0);
      chk("inv_fe_b", 32'(full_b & empty_b), 32'd0);
    end
  end

  initial begin
    op_a = 2'b00; ld_a = '0; clr_a = 1'b0;
    op_b = 2'b00; ld_b = '0; clr_b = 1'b0;
    reset = 1'b1;
    @(negedge CLK);

    cyc_a(2'b00, 0, 1'b0, 1'b0);
    cyc_a(2'b00, 0, 1'b0, 1'b0);
    cyc_a(2'b00, 0, 1'b0, 1'b0);
    chk("rst_sp",    sp_a,    16384);
    chk("rst_top",   top_a,   16383);
    chk("rst_count", cnt_a,   0);
    chk("rst_empty", empty_a, 1);
    chk("rst_full",  full_a,  0);
    chk("rst_ovf",   ovf_a,   0);
    chk("rst_unf",   unf_a,   0);
    chk("rstb_top",  top_b,   16382);

    cyc_a(2'b01, 0, 1'b0, 1'b0);
    chk("push1_sp",  sp_a,    16385);
    chk("push1_top", top_a,   16384);
    cyc_a(2'b01, 0, 1'b0, 1'b0);
    cyc_a(2'b01, 0, 1'b0, 1'b0);
    cyc_a(2'b01, 0, 1'b0, 1'b0);
    chk("push4_sp",    sp_a,   16388);
    chk("push4_top",   top_a,  16387);
    chk("push4_count", cnt_a,  4);
    chk("push4_full",  full_a, 1);
    chk("push4_ovf",   ovf_a,  0);

    cyc_a(2'b01, 0, 1'b0, 1'b0);
    chk("push5_sp",    sp_a,  16388);
    chk("push5_count", cnt_a, 4);
    chk("push5_ovf",   ovf_a, 1);

    cyc_a(2'b10, 0, 1'b0, 1'b0);
    chk("pop1_sp",   sp_a,   16387);
    chk("pop1_full", full_a, 0);
    cyc_a(2'b10, 0, 1'b0, 1'b0);
    cyc_a(2'b10, 0, 1'b0, 1'b0);
    cyc_a(2'b10, 0, 1'b0, 1'b0);
    chk("pop4_sp",    sp_a,    16384);
    chk("pop4_top",   top_a,   16383);
    chk("pop4_empty", empty_a, 1);
    chk("pop4_ovf",   ovf_a,   1);

    cyc_a(2'b10, 0, 1'b0, 1'b0);
    chk("popE_sp",  sp_a,  16384);
    chk("popE_unf", unf_a, 1);

    cyc_a(2'b10, 0, 1'b1, 1'b0);
    chk("popclr_unf", unf_a, 1);
    chk("popclr_ovf", ovf_a, 0);
    chk("popclr_sp",  sp_a,  16384);

    cyc_a(2'b00, 0, 1'b1, 1'b0);
    chk("clr_unf", unf_a, 0);

    cyc_a(2'b11, 3, 1'b0, 1'b0);
    chk("ld3_count", cnt_a, 3);
    chk("ld3_sp",    sp_a,  16387);
    chk("ld3_top",   top_a, 16386);
    chk("ld3_ovf",   ovf_a, 0);

    cyc_a(2'b11, 5, 1'b0, 1'b0);
    chk("ld5_sp",    sp_a,  16387);
    chk("ld5_count", cnt_a, 3);
    chk("ld5_ovf",   ovf_a, 1);

    cyc_a(2'b11, 4, 1'b0, 1'b0);
    chk("ld4_sp",   sp_a,   16388);
    chk("ld4_full", full_a, 1);

    cyc_a(2'b11, 0, 1'b0, 1'b0);
    chk("ld0_sp",    sp_a,    16384);
    chk("ld0_top",   top_a,   16383);
    chk("ld0_empty", empty_a, 1);

    cyc_a(2'b01, 0, 1'b0, 1'b0);
    cyc_a(2'b01, 0, 1'b0, 1'b0);
    chk("pre_rst_sp", sp_a, 16386);
    cyc_a(2'b01, 0, 1'b1, 1'b1);
    chk("mid_rst_sp",    sp_a,  16384);
    chk("mid_rst_count", cnt_a, 0);
    chk("mid_rst_ovf",   ovf_a, 0);
    chk("mid_rst_unf",   unf_a, 0);
    cyc_a(2'b01, 0, 1'b0, 1'b0);
    chk("post_rst_sp",    sp_a,  16385);
    chk("post_rst_count", cnt_a, 1);

    cyc_b(2'b01, 0);
    cyc_b(2'b01, 0);
    chk("b_push2_sp",  sp_b,  16388);
    chk("b_push2_top", top_b, 16386);
    cyc_b(2'b11, 8);
    chk("b_ld8_sp",   sp_b,   16400);
    chk("b_ld8_top",  top_b,  16398);
    chk("b_ld8_full", full_b, 1);
    chk("b_ld8_ovf",  ovf_b,  0);
    cyc_b(2'b10, 0);
    chk("b_pop_sp",    sp_b,  16398);
    chk("b_pop_top",   top_b, 16396);
    chk("b_pop_count", cnt_b, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_pointer_unit.md
Name: stack_pointer_unit

Overview:
- Parametrised stack-pointer generator for the processor's return and data stacks; successor to the fixed 16-bit, +1/−1/hold rp adder.
- Adds configurable base, depth and step, plus an absolute depth load.
- Adds full/empty status and sticky overflow/underflow error flags.
- Sits beside the stack memory: the control unit drives `op` every cycle, and `sp` and `top` address the stack RAM.

Parameters:
- WIDTH, 16: width of the pointer outputs.
- BASE, 16384: pointer value at reset, i.e. the empty-stack address (first free slot).
- DEPTH, 256: maximum number of entries; must be ≥ 1 and BASE + DEPTH*STEP must fit in WIDTH bits.
- STEP, 1: address increment per entry (e.g. 2 for byte-addressed 16-bit words); must be ≥ 1.
- Derived localparam CW = $clog2(DEPTH+1): width of the entry count.

Ports:
- CLK, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- op, input, 2: 00 hold, 01 push, 10 pop, 11 load.
- load_depth, input, CW: target entry count for op=11.
- err_clr, input, 1: clears both sticky error flags.
- sp, output, WIDTH: next free slot, always equal to BASE + count*STEP.
- top, output, WIDTH: address of the current top entry, sp − STEP; equals BASE − STEP (mod 2^WIDTH) when empty.
- count, output, CW: current number of entries.
- full, output, 1: count == DEPTH (combinational from registered count).
- empty, output, 1: count == 0 (combinational from registered count).
- overflow, output, 1: sticky; set by a push while full, or by a load with load_depth > DEPTH.
- underflow, output, 1: sticky; set by a pop while empty.

Behaviour:
- Reset (reset=1 at a rising edge): count=0, sp=BASE, top=BASE−STEP, overflow=0, underflow=0. Reset overrides op and err_clr.
- State registers: count, sp, top and the two flags.
- sp and top are registered and updated in the same cycle as count. They are not recomputed by multiplier.
- Latency: an op sampled at edge N is visible on all outputs after edge N; there is no combinational path from op to the outputs.
- Hold (00): no change.
- Push (01):
  - Not full: count+1, sp+STEP, top+STEP.
  - Full: pointer unchanged, overflow<=1.
- Pop (10):
  - Not empty: count−1, sp−STEP, top−STEP.
  - Empty: pointer unchanged, underflow<=1.
- Load (11):
  - load_depth ≤ DEPTH: count<=load_depth, sp<=BASE+load_depth*STEP, top<=sp−STEP. The multiply is constant-by-variable and is implemented with one multiplier in the load path only.
  - load_depth > DEPTH: ignored, overflow<=1.
- Arithmetic: sp and top are modulo 2^WIDTH. Parameter constraints guarantee that sp never wraps within the valid range; only top wraps, in the empty case.
- Error flags:
  - Once set, a flag stays set until err_clr or reset.
  - err_clr=1 with no new error in the same cycle: both flags <=0.
  - err_clr=1 in the same cycle as a new error: the new error wins (that flag is 1 next cycle); the other flag clears.
- An erroneous op never modifies count, sp or top.
- Reset asserted mid-sequence discards the pending op; the first op after reset deasserts is applied normally.
- Assertions in the bench/RTL:
  - sp == BASE + count*STEP at every cycle.
  - full and empty are never both 1 (DEPTH ≥ 1).

Decomposition:
- Shared package `stack_pkg` holds:
  - op encodings: SP_HOLD=2'b00, SP_PUSH=2'b01, SP_POP=2'b10, SP_LOAD=2'b11.
  - a helper function for the clog2 count width.
- One natural sub-module, `stack_bound_check`: combinational, takes count, op and load_depth and produces do_inc, do_dec, do_load, set_ovf and set_unf. The top level keeps the registers and adders, built from the existing adder_16b/reg_16b style primitives widened to WIDTH.

Test Plan (BASE=16384, DEPTH=4, STEP=1 unless noted):
- Reset then hold 3 cycles -> sp=16384, top=16383, count=0, empty=1, full=0, overflow=0, underflow=0.
- 4 pushes -> sp=16388, top=16387, count=4, full=1. A 5th push -> sp stays 16388, overflow=1. Then 4 pops -> sp=16384, empty=1, overflow still 1.
- Pop while empty -> sp=16384, underflow=1. Next cycle: pop with err_clr=1 -> underflow=1 (new error wins). Following cycle: err_clr with hold -> underflow=0.
- Load load_depth=3 -> count=3, sp=16387, top=16386. Load load_depth=5 -> ignored, sp=16387, overflow=1.
- STEP=2, DEPTH=8: push×2 -> sp=16388, top=16386. Load 8 -> sp=16400, full=1. Pop -> sp=16398.
- After 2 pushes, assert reset for 1 cycle together with push -> sp=16384, count=0, flags 0. Push next cycle -> sp=16385.
